gpio_in_port: RTL and testbench
===============================

Name: gpio_in_port

Overview:
- Memory-mapped input port: the read-side counterpart of the core's GPIO output register, which is written by a store to 0xABCD.
- An external producer pushes 32-bit words through a valid/ready handshake into a small FIFO.
- The single-cycle core drains the FIFO with loads to a data address and polls a status address.
- Sits beside the data memory. The core's load mux selects rd_data when hit=1.

Parameters:
- DEPTH, 4, FIFO depth in words; power of two, 2..256.
- ADDR_DATA, 32'h0000ABD0, load address returning the FIFO head word.
- ADDR_STAT, 32'h0000ABD4, load address returning the status word.

Ports:
- CLK  input  1  system clock, rising edge.
- Reset  input  1  synchronous, active-high.
- in_data  input  32  producer data word.
- in_valid  input  1  producer offers in_data this cycle.
- in_ready  output  1  port accepts a word this cycle.
- addr  input  32  core ALU result, the effective address.
- rd  input  1  core is executing a load this cycle.
- rd_data  output  32  read data to the core load mux.
- hit  output  1  addr matches ADDR_DATA or ADDR_STAT.

Behaviour:
- Reset: synchronous, active-high, on the rising CLK edge. Clears the write pointer, read pointer, count and the sticky overflow flag.
- Output values while and after Reset:
  - in_ready=1.
  - hit and rd_data follow addr, since both are combinational.
  - A read of ADDR_DATA returns 0; a read of ADDR_STAT returns 32'h1 (empty).
- FIFO storage is DEPTH x 32 registers with a circular read pointer and write pointer, each $clog2(DEPTH) bits wide.
  - Both pointers wrap modulo DEPTH.
  - count is $clog2(DEPTH)+1 bits wide, range 0..DEPTH.
- Push:
  - in_ready = (count != DEPTH), combinational from count.
  - On a rising edge with in_valid && in_ready, in_data is written at the write pointer and the write pointer increments.
  - The word becomes visible to reads in the next cycle (1-cycle latency).
- Overflow: in_valid && !in_ready on a rising edge sets the sticky overflow flag. The offered word is not stored. The producer may hold it and retry.
- Read data is combinational, because the core completes each load in one cycle:
  - hit = (addr==ADDR_DATA) || (addr==ADDR_STAT). hit does not depend on rd.
  - addr==ADDR_DATA: rd_data = head word if count!=0, else 32'h0.
  - addr==ADDR_STAT: rd_data[0] = empty, rd_data[1] = full, rd_data[2] = overflow, rd_data[3] = 0, rd_data[11:4] = count zero-extended to 8 bits, rd_data[31:12] = 0.
  - Otherwise rd_data = 32'h0.
- Pop: on a rising edge with rd && addr==ADDR_DATA && count!=0, the read pointer increments. A pop when empty has no effect.
- Status read side effect: on a rising edge with rd && addr==ADDR_STAT, overflow clears. If overflow is set in the same cycle, the set wins.
- Simultaneous push and pop:
  - count is unchanged and both pointers advance.
  - When empty, only the push takes effect; the core still reads 0 that cycle.
  - When full, in_ready=0 so only the pop occurs, and in_ready returns to 1 on the next cycle.
- A read of any address other than ADDR_DATA or ADDR_STAT has no state effect.
- Reset during any operation discards all queued words and clears overflow.

Test Plan:
1. Reset, then read ADDR_STAT -> rd_data=32'h1, in_ready=1. Read ADDR_DATA -> rd_data=0, hit=1.
2. Push 32'hCAFE0001, 32'hCAFE0002 on consecutive cycles:
   - ADDR_STAT reads 32'h20.
   - Two rd pulses at ADDR_DATA return 32'hCAFE0001 then 32'hCAFE0002.
   - ADDR_STAT then reads 32'h1.
3. With DEPTH=4, push 4 words then hold in_valid with a 5th:
   - in_ready=0 and ADDR_STAT reads 32'h46.
   - One pop -> in_ready=1 next cycle, the held word is accepted, and it is read out last in order.
4. After the overflow in test 3, rd at ADDR_STAT -> returns bit2=1, next status read shows bit2=0. In a cycle that both sets and clears overflow, the flag stays 1.
5. Push and pop in the same cycle:
   - At count=2 -> count stays 2 and order is preserved.
   - At count=0 -> rd_data=0 and count becomes 1.
6. Push 10 words with interleaved pops (wrap past DEPTH) -> all 10 words read back in order, no loss. Assert Reset with 3 words queued -> status 32'h1, next ADDR_DATA read returns 0.

Source files
------------

// File: rtl/gpio_in_port.sv
// gpio_in_port: memory-mapped input FIFO read by the single-cycle core.
// A producer pushes 32-bit words over valid/ready. The core pops the head
// word with a load from ADDR_DATA and polls status at ADDR_STAT.
module gpio_in_port #(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] ADDR_DATA = 32'h0000ABD0,
    parameter logic [31:0] ADDR_STAT = 32'h0000ABD4
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] addr,
    input  logic        rd,
    output logic [31:0] rd_data,
    output logic        hit
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          overflow;

    logic is_data, is_stat, empty, full, push, pop;
    logic [7:0] count8;

    assign is_data  = (addr == ADDR_DATA);
    assign is_stat  = (addr == ADDR_STAT);
    assign hit      = is_data || is_stat;
    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    assign in_ready = !full;
    assign push     = in_valid && in_ready;
    // A pop on an empty FIFO is silently ignored.
    assign pop      = rd && is_data && !empty;
    // Status field is 8 bits; only DEPTH=256 full would not fit and wraps.
    assign count8   = 8'(count);

    // Word storage; no reset needed since count gates every read.
    always_ff @(posedge CLK) begin
        if (push)
            mem[wr_ptr] <= in_data;
    end

    // Pointers, occupancy and the sticky overflow flag.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)
                count <= count + CW'(1);
            else if (pop && !push)
                count <= count - CW'(1);
            // A new overflow beats the clear-on-status-read.
            if (in_valid && !in_ready)
                overflow <= 1'b1;
            else if (rd && is_stat)
                overflow <= 1'b0;
        end
    end

    // Combinational read data so the core completes loads in one cycle.
    always_comb begin
        rd_data = 32'h0;
        if (is_data) begin
            if (!empty)
                rd_data = mem[rd_ptr];
        end else if (is_stat) begin
            rd_data = {20'h0, count8, 1'b0, overflow, full, empty};
        end
    end
endmodule

// File: tb/tb_gpio_in_port.sv
// tb_gpio_in_port: scoreboard bench for gpio_in_port (DEPTH=4).
// Accepted words are queued in the model when driven and compared against
// rd_data when the core pops them.
module tb_gpio_in_port;
    localparam int          DEPTH = 4;
    localparam logic [31:0] AD    = 32'h0000ABD0;
    localparam logic [31:0] AS    = 32'h0000ABD4;

    logic        CLK = 1'b0;
    logic        Reset = 1'b1;
    logic [31:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] addr = '0;
    logic        rd = 1'b0;
    logic [31:0] rd_data;
    logic        hit;

    gpio_in_port #(.DEPTH(DEPTH), .ADDR_DATA(AD), .ADDR_STAT(AS)) dut (
        .CLK(CLK), .Reset(Reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .addr(addr), .rd(rd), .rd_data(rd_data), .hit(hit)
    );

    always #5 CLK = ~CLK;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] sb[$];
    logic        m_ovf = 1'b0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    // One core/producer cycle: drive, check combinational outputs, then
    // advance the model to match what the coming rising edge should do.
    task automatic step(input logic v, input logic [31:0] d,
                        input logic [31:0] a, input logic r);
        logic        e_ready;
        logic [31:0] e_data;
        logic [7:0]  sz;
        @(negedge CLK);
        in_valid = v; in_data = d; addr = a; rd = r;
        #1;
        sz      = 8'(sb.size());
        e_ready = (sb.size() != DEPTH);
        e_data  = 32'h0;
        if (a == AD)
            e_data = (sb.size() != 0) ? sb[0] : 32'h0;
        else if (a == AS)
            e_data = {20'h0, sz, 1'b0, m_ovf, !e_ready, sb.size() == 0};
        chk("in_ready", {31'h0, in_ready}, {31'h0, e_ready});
        chk("hit", {31'h0, hit}, {31'h0, (a == AD) || (a == AS)});
        chk(a == AS ? "status" : "rd_data", rd_data, e_data);
        if (r && a == AD && sb.size() != 0)
            void'(sb.pop_front());
        if (v && e_ready)
            sb.push_back(d);
        if (v && !e_ready)
            m_ovf = 1'b1;
        else if (r && a == AS)
            m_ovf = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        Reset = 1'b1; in_valid = 1'b0; rd = 1'b0;
        @(negedge CLK);
        Reset = 1'b0;
        sb.delete();
        m_ovf = 1'b0;
    endtask

    task automatic drain();
        while (sb.size() != 0)
            step(1'b0, 32'h0, AD, 1'b1);
    endtask

    initial begin
        // 1: reset state
        do_reset();
        step(0, 0, AS, 1);
        step(0, 0, AD, 1);
        step(0, 0, 32'h0000ABCD, 1);

        // 2: two pushes, status 0x20, read back in order
        step(1, 32'hCAFE0001, 0, 0);
        step(1, 32'hCAFE0002, 0, 0);
        step(0, 0, AS, 0);
        chk("stat_two", rd_data, 32'h20);
        step(0, 0, AD, 1);
        step(0, 0, AD, 1);
        step(0, 0, AS, 0);
        chk("stat_empty", rd_data, 32'h1);

        // 3: fill, hold a fifth word, pop once so it is accepted
        for (int i = 0; i < DEPTH; i++)
            step(1, 32'hA000_0000 + i, 0, 0);
        step(1, 32'hA000_00FF, AS, 0);
        step(1, 32'hA000_00FF, AS, 0);
        chk("stat_full_ovf", rd_data, 32'h46);
        step(1, 32'hA000_00FF, AD, 1);
        step(1, 32'hA000_00FF, 0, 0);

        // 4: overflow clear on status read; set beats clear
        step(0, 0, AS, 1);
        step(0, 0, AS, 1);
        step(1, 32'hBAD0_0000, AS, 1);
        step(0, 0, AS, 0);
        chk("ovf_set_wins", rd_data & 32'h4, 32'h4);
        drain();
        step(0, 0, AS, 1);

        // 5: simultaneous push/pop at count=2 and at empty
        step(1, 32'h5000_0001, 0, 0);
        step(1, 32'h5000_0002, 0, 0);
        step(1, 32'h5000_0003, AD, 1);
        step(0, 0, AS, 0);
        chk("pp_count2", rd_data, 32'h20);
        drain();
        step(1, 32'h5000_0004, AD, 1);
        step(0, 0, AS, 0);
        chk("pp_empty", rd_data, 32'h10);
        drain();

        // 6: ten words with interleaved pops wrapping the pointers
        for (int i = 0; i < 10; i++)
            step(1, 32'h6000_0000 + i, AD, i[0]);
        drain();
        for (int i = 0; i < 3; i++)
            step(1, 32'h7000_0000 + i, 0, 0);
        do_reset();
        step(0, 0, AS, 0);
        chk("reset_stat", rd_data, 32'h1);
        step(0, 0, AD, 1);

        // mixed random traffic
        for (int i = 0; i < 200; i++) begin
            logic [1:0] s;
            logic [31:0] a;
            s = 2'($urandom_range(0, 3));
            a = (s == 0) ? AS : (s == 3) ? 32'h0000ABD8 : AD;
            step(1'($urandom_range(0, 1)), $urandom, a, 1'($urandom_range(0, 1)));
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
